toy_ld_req_arb: RTL and testbench

- Sequences load address packets from NUM_REQ load address-generation lanes onto the single data-memory read request port.
- Each lane has a one-entry holding buffer; the block arbitrates round-robin among them and locks a grant until the memory side accepts it.
- Limits in-flight reads with an outstanding-credit counter that is returned on memory acks.
- Sits between the load AGU lanes and the D-side memory/cache request interface; supports pipeline flush.

---
 rtl/toy_ld_req_arb_if.sv | 33 +++
 rtl/toy_ld_req_arb.sv | 127 ++++++++++++
 tb/tb_toy_ld_req_arb.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toy_ld_req_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : toy_ld_req_arb_if
// Brief    : Load-lane intake, memory request and memory ack signal bundle
//            for the load request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface toy_ld_req_arb_if #(
    parameter int NUM_REQ = 2,
    parameter int PLD_W   = 64,
    parameter int SRC_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            s_load_vld;
    logic [NUM_REQ-1:0]            s_load_rdy;
    logic [NUM_REQ-1:0][PLD_W-1:0] s_load_pld;
    logic                          m_mem_req_vld;
    logic                          m_mem_req_rdy;
    logic [PLD_W-1:0]              m_mem_req_pld;
    logic [SRC_W-1:0]              m_mem_req_src;
    logic                          s_mem_ack_vld;

    // master: the arbiter itself; slave: the AGU lanes plus memory side
    modport master (
        input  s_load_vld, s_load_pld, m_mem_req_rdy, s_mem_ack_vld,
        output s_load_rdy, m_mem_req_vld, m_mem_req_pld, m_mem_req_src
    );

    modport slave (
        output s_load_vld, s_load_pld, m_mem_req_rdy, s_mem_ack_vld,
        input  s_load_rdy, m_mem_req_vld, m_mem_req_pld, m_mem_req_src
    );
endinterface
`default_nettype wire

// File: rtl/toy_ld_req_arb.sv
`default_nettype none
// ============================================================================
// Module   : toy_ld_req_arb
// Brief    : Round-robin arbiter from per-lane one-entry load buffers onto a
//            single D-side read request port, with outstanding-read credits.
// Revision : 1.0 - initial release
// ============================================================================
module toy_ld_req_arb #(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int PLD_W           = 64,
    parameter int SRC_W           = $clog2(NUM_REQ)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    toy_ld_req_arb_if.master bus,
    input  wire logic        flush,
    output logic [3:0]       outstanding_cnt,
    output logic             ack_underflow_err
);
    localparam logic [3:0] c_max_out = 4'(MAX_OUTSTANDING);

    logic [NUM_REQ-1:0]            r_buf_vld;
    logic [NUM_REQ-1:0][PLD_W-1:0] r_buf;
    logic [SRC_W-1:0]              r_rr_ptr;
    logic [SRC_W-1:0]              r_sel_idx;
    logic                          r_lock;
    logic [3:0]                    r_cnt;
    logic                          r_err;

    logic [SRC_W-1:0]              w_rr_pick;
    logic [SRC_W-1:0]              w_sel_idx;
    logic                          w_credit_ok;
    logic                          w_req_vld;
    logic                          w_hs;
    logic [NUM_REQ-1:0]            w_load_rdy;
    logic [NUM_REQ-1:0]            w_accept;

    assign w_credit_ok = (r_cnt < c_max_out);
    assign w_req_vld   = (|r_buf_vld) & w_credit_ok & ~flush;
    assign w_hs        = w_req_vld & bus.m_mem_req_rdy;
    assign w_load_rdy  = ~r_buf_vld & {NUM_REQ{~flush}};
    assign w_accept    = bus.s_load_vld & w_load_rdy;

    // First valid buffer at or above rr_ptr; the index add wraps because
    // NUM_REQ is a power of two.
    always_comb begin : rr_scan
        logic [SRC_W-1:0] v_idx;
        logic             v_found;
        w_rr_pick = r_rr_ptr;
        v_found   = 1'b0;
        v_idx     = r_rr_ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_idx = r_rr_ptr + SRC_W'(k);
            if (!v_found && r_buf_vld[v_idx]) begin
                w_rr_pick = v_idx;
                v_found   = 1'b1;
            end
        end
    end

    assign w_sel_idx = r_lock ? r_sel_idx : w_rr_pick;

    assign bus.s_load_rdy    = w_load_rdy;
    assign bus.m_mem_req_vld = w_req_vld;
    assign bus.m_mem_req_pld = r_buf[w_sel_idx];
    assign bus.m_mem_req_src = w_sel_idx;
    assign outstanding_cnt   = r_cnt;
    assign ack_underflow_err = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_vld <= '0;
            r_buf     <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (flush) begin
                    r_buf_vld[i] <= 1'b0;
                end else if (w_accept[i]) begin
                    r_buf_vld[i] <= 1'b1;
                    r_buf[i]     <= bus.s_load_pld[i];
                end else if (w_hs && (w_sel_idx == SRC_W'(i))) begin
                    r_buf_vld[i] <= 1'b0;
                end
            end
        end
    end

    // A stalled request pins its lane so payload and source stay stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_sel_idx <= '0;
            r_lock    <= 1'b0;
        end else begin
            r_sel_idx <= w_sel_idx;
            if (flush) begin
                r_lock <= 1'b0;
            end else if (w_hs) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_sel_idx + 1'b1;
            end else if (w_req_vld) begin
                r_lock <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
            r_err <= 1'b0;
        end else begin
            case ({w_hs, bus.s_mem_ack_vld})
                2'b10: r_cnt <= r_cnt + 4'd1;
                2'b01: begin
                    if (r_cnt == 4'd0) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_toy_ld_req_arb.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_toy_ld_req_arb
// Brief    : Directed scoreboard bench for the load request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toy_ld_req_arb;
    localparam int NUM_REQ = 2;
    localparam int MAX_OUT = 4;
    localparam int PLD_W   = 32;
    localparam int SRC_W   = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] outstanding_cnt;
    logic       ack_underflow_err;

    toy_ld_req_arb_if #(.NUM_REQ(NUM_REQ), .PLD_W(PLD_W), .SRC_W(SRC_W)) bus ();

    toy_ld_req_arb #(
        .NUM_REQ(NUM_REQ), .MAX_OUTSTANDING(MAX_OUT), .PLD_W(PLD_W), .SRC_W(SRC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .flush(flush),
        .outstanding_cnt(outstanding_cnt), .ack_underflow_err(ack_underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [PLD_W-1:0] pld;
    } exp_t;

    exp_t             exp_q[$];
    logic [PLD_W-1:0] lane0_q[$];
    logic [PLD_W-1:0] lane1_q[$];
    int               n_vec = 0;
    int               n_err = 0;
    int               n_hs  = 0;
    int               hs_base;
    logic             prev_stall = 1'b0;
    exp_t             prev_out;
    exp_t             cur;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int src, input logic [PLD_W-1:0] pld);
        exp_t e;
        e.src = SRC_W'(src);
        e.pld = pld;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake pops the scoreboard; a stalled request must
    // reappear unchanged on the following cycle.
    always @(negedge clk) begin
        cur.src = bus.m_mem_req_src;
        cur.pld = bus.m_mem_req_pld;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.m_mem_req_vld) begin
                if (prev_stall) chk("lock_hold", 64'(cur), 64'(prev_out));
                if (bus.m_mem_req_rdy) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_issue: got src=%0d pld=%0h, expected no issue",
                                 cur.src, cur.pld);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("issue_src", 64'(cur.src), 64'(e.src));
                        chk("issue_pld", 64'(cur.pld), 64'(e.pld));
                    end
                end
            end
            prev_stall = bus.m_mem_req_vld & ~bus.m_mem_req_rdy;
            prev_out   = cur;
        end
    end

    // Lane feeder: each lane presents the head of its queue until accepted;
    // optional ack one cycle after every handshake.
    task automatic run(input int n_cyc, input bit auto_ack);
        bit acc0, acc1, hs;
        for (int c = 0; c < n_cyc; c++) begin
            bus.s_load_vld[0] = (lane0_q.size() != 0);
            if (lane0_q.size() != 0) bus.s_load_pld[0] = lane0_q[0];
            bus.s_load_vld[1] = (lane1_q.size() != 0);
            if (lane1_q.size() != 0) bus.s_load_pld[1] = lane1_q[0];
            @(negedge clk);
            acc0 = bus.s_load_vld[0] & bus.s_load_rdy[0];
            acc1 = bus.s_load_vld[1] & bus.s_load_rdy[1];
            hs   = bus.m_mem_req_vld & bus.m_mem_req_rdy;
            tick();
            if (acc0) void'(lane0_q.pop_front());
            if (acc1) void'(lane1_q.pop_front());
            bus.s_mem_ack_vld = auto_ack & hs;
        end
        bus.s_load_vld    = '0;
        bus.s_mem_ack_vld = 1'b0;
    endtask

    task automatic acks(input int n);
        bus.s_mem_ack_vld = 1'b1;
        repeat (n) tick();
        bus.s_mem_ack_vld = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.s_load_vld    = '0;
        bus.s_load_pld    = '0;
        bus.m_mem_req_rdy = 1'b0;
        bus.s_mem_ack_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_rdy", 64'(bus.s_load_rdy), 64'h3);
        chk("rst_req_vld", 64'(bus.m_mem_req_vld), 64'h0);
        chk("rst_req_pld", 64'(bus.m_mem_req_pld), 64'h0);
        chk("rst_req_src", 64'(bus.m_mem_req_src), 64'h0);
        chk("rst_cnt", 64'(outstanding_cnt), 64'h0);
        chk("rst_err", 64'(ack_underflow_err), 64'h0);
        rst_n = 1'b1;

        // Round-robin: both lanes continuously valid, acks trailing issues
        bus.m_mem_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lane0_q.push_back(32'hA000_0000 + 32'(k));
            lane1_q.push_back(32'hB000_0000 + 32'(k));
            push_exp(0, 32'hA000_0000 + 32'(k));
            push_exp(1, 32'hB000_0000 + 32'(k));
        end
        hs_base = n_hs;
        run(8, 1'b1);
        chk("rr_hs_count", 64'(n_hs - hs_base), 64'd6);
        chk("rr_cnt", 64'(outstanding_cnt), 64'd0);
        chk("rr_drained", 64'(exp_q.size()), 64'd0);

        // Grant lock: lane 1 stalls, lane 0 fills behind it
        bus.m_mem_req_rdy = 1'b0;
        push_exp(1, 32'hC000_0001);
        push_exp(0, 32'hD000_0000);
        bus.s_load_vld    = 2'b10;
        bus.s_load_pld[1] = 32'hC000_0001;
        tick();
        bus.s_load_vld = '0;
        #1;
        chk("lock_first_src", 64'(bus.m_mem_req_src), 64'd1);
        chk("lock_first_vld", 64'(bus.m_mem_req_vld), 64'd1);
        tick();
        bus.s_load_vld    = 2'b01;
        bus.s_load_pld[0] = 32'hD000_0000;
        tick();
        bus.s_load_vld = '0;
        #1;
        chk("lock_src", 64'(bus.m_mem_req_src), 64'd1);
        chk("lock_pld", 64'(bus.m_mem_req_pld), 64'hC000_0001);
        tick();
        bus.m_mem_req_rdy = 1'b1;
        tick();
        chk("lock_next_src", 64'(bus.m_mem_req_src), 64'd0);
        chk("lock_next_pld", 64'(bus.m_mem_req_pld), 64'hD000_0000);
        chk("lock_cnt1", 64'(outstanding_cnt), 64'd1);
        tick();
        bus.m_mem_req_rdy = 1'b0;
        #1;
        chk("lock_idle_vld", 64'(bus.m_mem_req_vld), 64'd0);
        chk("lock_cnt2", 64'(outstanding_cnt), 64'd2);
        acks(2);
        chk("lock_cnt0", 64'(outstanding_cnt), 64'd0);

        // Credit limit: six loads, no acks
        bus.m_mem_req_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            lane0_q.push_back(32'hE000_0000 + 32'(k));
            lane1_q.push_back(32'hF000_0000 + 32'(k));
        end
        push_exp(1, 32'hF000_0000);
        push_exp(0, 32'hE000_0000);
        push_exp(1, 32'hF000_0001);
        push_exp(0, 32'hE000_0001);
        push_exp(1, 32'hF000_0002);
        push_exp(0, 32'hE000_0002);
        hs_base = n_hs;
        run(8, 1'b0);
        chk("cr_hs_count", 64'(n_hs - hs_base), 64'd4);
        chk("cr_cnt_full", 64'(outstanding_cnt), 64'd4);
        chk("cr_vld_blocked", 64'(bus.m_mem_req_vld), 64'd0);
        chk("cr_all_taken", 64'(lane0_q.size() + lane1_q.size()), 64'd0);
        bus.s_mem_ack_vld = 1'b1;
        tick();
        chk("cr_cnt_after_ack", 64'(outstanding_cnt), 64'd3);
        chk("cr_vld_resumes", 64'(bus.m_mem_req_vld), 64'd1);
        tick();
        bus.s_mem_ack_vld = 1'b0;
        chk("cr_hs_plus_ack", 64'(outstanding_cnt), 64'd3);
        tick();
        chk("cr_cnt_refull", 64'(outstanding_cnt), 64'd4);
        chk("cr_vld_empty", 64'(bus.m_mem_req_vld), 64'd0);
        acks(4);
        chk("cr_cnt_drain", 64'(outstanding_cnt), 64'd0);

        // Flush: lane-0 traffic leaves rr_ptr at 1 and cnt at 2
        lane0_q.push_back(32'h1000_0000);
        lane0_q.push_back(32'h1000_0001);
        push_exp(0, 32'h1000_0000);
        push_exp(0, 32'h1000_0001);
        run(5, 1'b0);
        bus.m_mem_req_rdy = 1'b0;
        lane0_q.push_back(32'h2000_0000);
        lane1_q.push_back(32'h2000_0001);
        run(2, 1'b0);
        chk("fl_pre_rdy", 64'(bus.s_load_rdy), 64'h0);
        chk("fl_pre_cnt", 64'(outstanding_cnt), 64'd2);
        flush             = 1'b1;
        bus.m_mem_req_rdy = 1'b1;
        bus.s_mem_ack_vld = 1'b1;
        bus.s_load_vld    = 2'b11;
        #1;
        chk("fl_rdy_low", 64'(bus.s_load_rdy), 64'h0);
        chk("fl_vld_low", 64'(bus.m_mem_req_vld), 64'd0);
        tick();
        flush             = 1'b0;
        bus.s_mem_ack_vld = 1'b0;
        bus.s_load_vld    = '0;
        #1;
        chk("fl_bufs_empty", 64'(bus.s_load_rdy), 64'h3);
        chk("fl_no_req", 64'(bus.m_mem_req_vld), 64'd0);
        chk("fl_cnt_ack", 64'(outstanding_cnt), 64'd1);
        acks(1);
        chk("fl_cnt0", 64'(outstanding_cnt), 64'd0);
        chk("fl_err0", 64'(ack_underflow_err), 64'd0);
        lane0_q.push_back(32'h3000_0000);
        lane1_q.push_back(32'h3000_0001);
        push_exp(1, 32'h3000_0001);
        push_exp(0, 32'h3000_0000);
        run(4, 1'b0);
        chk("fl_rr_cnt", 64'(outstanding_cnt), 64'd2);
        acks(2);

        // Underflow: ack with nothing outstanding
        acks(1);
        chk("uf_cnt", 64'(outstanding_cnt), 64'd0);
        chk("uf_err", 64'(ack_underflow_err), 64'd1);
        repeat (3) tick();
        chk("uf_sticky", 64'(ack_underflow_err), 64'd1);

        // Reset mid-traffic: cnt=3, both buffers full, rr_ptr at 1
        for (int k = 0; k < 3; k++) begin
            lane0_q.push_back(32'h4000_0000 + 32'(k));
            push_exp(0, 32'h4000_0000 + 32'(k));
        end
        run(6, 1'b0);
        bus.m_mem_req_rdy = 1'b0;
        lane0_q.push_back(32'h5000_0000);
        lane1_q.push_back(32'h5000_0001);
        run(2, 1'b0);
        chk("mr_pre_cnt", 64'(outstanding_cnt), 64'd3);
        chk("mr_pre_rdy", 64'(bus.s_load_rdy), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("mr_rdy", 64'(bus.s_load_rdy), 64'h3);
        chk("mr_vld", 64'(bus.m_mem_req_vld), 64'd0);
        chk("mr_cnt", 64'(outstanding_cnt), 64'd0);
        chk("mr_err", 64'(ack_underflow_err), 64'd0);
        tick();
        chk("mr_edge_rdy", 64'(bus.s_load_rdy), 64'h3);
        chk("mr_edge_src", 64'(bus.m_mem_req_src), 64'd0);
        rst_n             = 1'b1;
        bus.m_mem_req_rdy = 1'b1;
        lane0_q.push_back(32'h6000_0000);
        lane1_q.push_back(32'h6000_0001);
        push_exp(0, 32'h6000_0000);
        push_exp(1, 32'h6000_0001);
        run(4, 1'b0);
        chk("mr_post_cnt", 64'(outstanding_cnt), 64'd2);
        acks(2);
        chk("final_cnt", 64'(outstanding_cnt), 64'd0);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
